// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, RAM handshake states, arbiter FSM states
// and the transaction record latched at grant.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned STAT_W   = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IFETCH  = 3'd1,
        DLOAD   = 3'd2,
        DSTORE  = 3'd3,
        RECOVER = 3'd4
    } arb_state_t;

    // Transaction captured on the grant edge; replayed unchanged after an error.
    typedef struct packed {
        arb_state_t kind;
        word_t      addr;
        word_t      store;
    } xact_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter.
// slave: the arbiter's view; master: the caches + RAM model driving it.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while an instruction fetch waits;
// saturates at STARVE_MAX so the arbiter can force a fetch through.
module arb_starve_ctr
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_max
);

    localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(STARVE_MAX);

    // Saturating counter; clear has priority over increment.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data requesters.
// Data requests win unless an instruction fetch has been passed over
// STARVE_MAX times in a row. RAM errors trigger one recovery cycle and a
// retry of the latched transaction.
// Optional: define MEM_ARB_STATS_EN for grant/error statistics ports.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    mem_arbiter_if.slave      bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] igrants,
    output logic [STAT_W-1:0] dgrants,
    output logic [STAT_W-1:0] errcnt
`endif
);

    arb_state_t          state, state_nxt;
    xact_t               xact_q, xact_nxt;
    logic [ADDR_W-1:0]   grant_addr_c;
    logic                starve_inc_c, starve_clr_c;
    logic                starve_at_max;
    logic [STARVE_W-1:0] starve_cnt;
    logic                active_c, idone_c, ddone_c;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (starve_inc_c),
        .clr    (starve_clr_c),
        .cnt    (starve_cnt),
        .at_max (starve_at_max)
    );

    // State and latched transaction registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            xact_q <= '{kind: IDLE, addr: '0, store: '0};
        end else begin
            state  <= state_nxt;
            xact_q <= xact_nxt;
        end
    end

    // Arbitration, grant capture and completion/error sequencing.
    always_comb begin
        state_nxt    = state;
        xact_nxt     = xact_q;
        grant_addr_c = '0;
        starve_inc_c = 1'b0;
        starve_clr_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.iREN) begin
                    starve_clr_c = 1'b1;
                end
                if (bus.iREN && starve_at_max) begin
                    state_nxt    = IFETCH;
                    grant_addr_c = ADDR_W'(bus.iaddr);
                    starve_clr_c = 1'b1;
                end else if (bus.dWEN) begin
                    state_nxt      = DSTORE;
                    grant_addr_c   = ADDR_W'(bus.daddr);
                    xact_nxt.store = bus.dstore;
                    starve_inc_c   = bus.iREN;
                end else if (bus.dREN) begin
                    state_nxt    = DLOAD;
                    grant_addr_c = ADDR_W'(bus.daddr);
                    starve_inc_c = bus.iREN;
                end else if (bus.iREN) begin
                    state_nxt    = IFETCH;
                    grant_addr_c = ADDR_W'(bus.iaddr);
                    starve_clr_c = 1'b1;
                end
                if (state_nxt != IDLE) begin
                    xact_nxt.kind = state_nxt;
                    xact_nxt.addr = word_t'(grant_addr_c);
                end
            end
            IFETCH, DLOAD, DSTORE: begin
                if (bus.ramstate == ACCESS) begin
                    state_nxt = IDLE;
                end else if (bus.ramstate == ERROR) begin
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                state_nxt = xact_q.kind;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Completion is only signalled to a requester that is still asking.
    assign active_c = (state == IFETCH) || (state == DLOAD) || (state == DSTORE);
    assign idone_c  = (state == IFETCH) && (bus.ramstate == ACCESS) && bus.iREN;
    assign ddone_c  = ((state == DLOAD) || (state == DSTORE)) &&
                      (bus.ramstate == ACCESS) && (bus.dREN || bus.dWEN);

    // RAM strobes decode from the state register so reset drops them at once.
    assign bus.ramREN   = (state == IFETCH) || (state == DLOAD);
    assign bus.ramWEN   = (state == DSTORE);
    assign bus.ramaddr  = xact_q.addr;
    assign bus.ramstore = xact_q.store;

    // Requester responses, valid in the completion cycle only.
    assign bus.iwait = !idone_c;
    assign bus.iload = idone_c ? bus.ramload : '0;
    assign bus.dwait = !ddone_c;
    assign bus.dload = (ddone_c && (state == DLOAD)) ? bus.ramload : '0;

`ifdef MEM_ARB_STATS_EN
    logic igrant_c, dgrant_c, err_c;

    assign igrant_c = (state == IDLE) && (state_nxt == IFETCH);
    assign dgrant_c = (state == IDLE) && ((state_nxt == DLOAD) || (state_nxt == DSTORE));
    assign err_c    = active_c && (bus.ramstate == ERROR);

    // Saturating grant and error statistics.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrants <= '0;
            dgrants <= '0;
            errcnt  <= '0;
        end else begin
            if (igrant_c) igrants <= sat_inc(igrants);
            if (dgrant_c) dgrants <= sat_inc(dgrants);
            if (err_c)    errcnt  <= sat_inc(errcnt);
        end
    end
`else
    logic unused_active_c;
    assign unused_active_c = active_c;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, priority, starvation,
// store retry after error, abandoned request.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   tests_run;
    int   tests_failed;

    mem_arbiter_if bus();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] igrants, dgrants, errcnt;
`endif

    mem_arbiter #(
        .STARVE_MAX (4),
        .ADDR_W     (32)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .igrants (igrants),
        .dgrants (dgrants),
        .errcnt  (errcnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
            $display("FAIL reset_strobes: got ren=%0b wen=%0b want 0 0", bus.ramREN, bus.ramWEN); tests_failed++;
        end
        tests_run++;
        if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.iload !== 32'h0 || bus.dload !== 32'h0 || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
            $display("FAIL reset_outputs: got iwait=%0b dwait=%0b iload=%h dload=%h addr=%h store=%h", bus.iwait, bus.dwait, bus.iload, bus.dload, bus.ramaddr, bus.ramstore); tests_failed++;
        end
        nRST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (dut.state !== IDLE) begin
            $display("FAIL reset_state: got %0d want IDLE", dut.state); tests_failed++;
        end
        // Asynchronous reset in the middle of a fetch.
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h7C; bus.ramstate = ACCESS;
        tick();
        tests_run++;
        if (bus.ramREN !== 1'b1 || bus.iwait !== 1'b0) begin
            $display("FAIL reset_pre_fetch: got ren=%0b iwait=%0b want 1 0", bus.ramREN, bus.iwait); tests_failed++;
        end
        #2 nRST = 1'b0;
        #1;
        tests_run++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.ramaddr !== 32'h0) begin
            $display("FAIL reset_async: got ren=%0b iwait=%0b addr=%h want 0 1 0", bus.ramREN, bus.iwait, bus.ramaddr); tests_failed++;
        end
        bus.iREN = 1'b0; bus.ramstate = FREE;
        tick();
        nRST = 1'b1;
        tick();
        @(negedge CLK);
        tests_run++;
        if (dut.state !== IDLE || bus.ramREN !== 1'b0) begin
            $display("FAIL reset_no_retry: got state=%0d ren=%0b want IDLE 0", dut.state, bus.ramREN); tests_failed++;
        end
    endtask

    task automatic test_fetch();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = FREE;
        @(negedge CLK);
        tests_run++;
        if (bus.iwait !== 1'b1) begin
            $display("FAIL fetch_idle_iwait: got %0b want 1", bus.iwait); tests_failed++;
        end
        tick();
        bus.ramstate = BUSY;
        @(negedge CLK);
        tests_run++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.iwait !== 1'b1) begin
            $display("FAIL fetch_busy1: got ren=%0b addr=%h iwait=%0b want 1 40 1", bus.ramREN, bus.ramaddr, bus.iwait); tests_failed++;
        end
        tick();
        @(negedge CLK);
        tests_run++;
        if (bus.iwait !== 1'b1 || bus.ramaddr !== 32'h40) begin
            $display("FAIL fetch_busy2: got iwait=%0b addr=%h want 1 40", bus.iwait, bus.ramaddr); tests_failed++;
        end
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h2402000A;
        @(negedge CLK);
        tests_run++;
        if (bus.iwait !== 1'b0 || bus.iload !== 32'h2402000A || bus.dwait !== 1'b1) begin
            $display("FAIL fetch_done: got iwait=%0b iload=%h dwait=%0b want 0 2402000a 1", bus.iwait, bus.iload, bus.dwait); tests_failed++;
        end
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        @(negedge CLK);
        tests_run++;
        if (bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin
            $display("FAIL fetch_after: got iwait=%0b ren=%0b want 1 0", bus.iwait, bus.ramREN); tests_failed++;
        end
    endtask

    task automatic test_priority();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.ramstate = FREE;
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h11;
        @(negedge CLK);
        tests_run++;
        if (bus.ramaddr !== 32'h100 || bus.dwait !== 1'b0 || bus.dload !== 32'h11 || bus.iwait !== 1'b1) begin
            $display("FAIL prio_data_first: got addr=%h dwait=%0b dload=%h iwait=%0b want 100 0 11 1", bus.ramaddr, bus.dwait, bus.dload, bus.iwait); tests_failed++;
        end
        tick();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        @(negedge CLK);
        tests_run++;
        if (bus.ramREN !== 1'b0 || bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
            $display("FAIL prio_idle_gap: got ren=%0b iwait=%0b dwait=%0b want 0 1 1", bus.ramREN, bus.iwait, bus.dwait); tests_failed++;
        end
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h22;
        @(negedge CLK);
        tests_run++;
        if (bus.ramaddr !== 32'h44 || bus.iwait !== 1'b0 || bus.iload !== 32'h22) begin
            $display("FAIL prio_fetch_next: got addr=%h iwait=%0b iload=%h want 44 0 22", bus.ramaddr, bus.iwait, bus.iload); tests_failed++;
        end
        tick();
        bus.iREN = 1'b0; bus.ramstate = FREE;
    endtask

    task automatic test_starvation();
        tick();
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h300;
        bus.ramstate = ACCESS; bus.ramload = 32'h33;
        for (int g = 0; g < 5; g++) begin
            tick();
            @(negedge CLK);
            tests_run++;
            if (g < 4) begin
                if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1 || bus.ramaddr !== 32'h300) begin
                    $display("FAIL starve_grant%0d: got dwait=%0b iwait=%0b addr=%h want data grant at 300", g, bus.dwait, bus.iwait, bus.ramaddr); tests_failed++;
                end
            end else begin
                if (bus.iwait !== 1'b0 || bus.dwait !== 1'b1 || bus.ramaddr !== 32'h80) begin
                    $display("FAIL starve_grant%0d: got iwait=%0b dwait=%0b addr=%h want fetch grant at 80", g, bus.iwait, bus.dwait, bus.ramaddr); tests_failed++;
                end
                tests_run++;
                if (dut.u_starve.cnt !== 4'd0) begin
                    $display("FAIL starve_cnt_clear: got %0d want 0", dut.u_starve.cnt); tests_failed++;
                end
            end
            tick();
            if (g == 4) begin
                bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
            end
            @(negedge CLK);
            tests_run++;
            if (bus.ramREN !== 1'b0) begin
                $display("FAIL starve_gap%0d: got ren=%0b want 0", g, bus.ramREN); tests_failed++;
            end
        end
    endtask

    task automatic test_store_error();
        tick();
        bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF; bus.ramstate = FREE;
        tick();
        bus.ramstate = ERROR;
        @(negedge CLK);
        tests_run++;
        if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'hDEADBEEF || bus.dwait !== 1'b1) begin
            $display("FAIL store_first: got wen=%0b ren=%0b addr=%h store=%h dwait=%0b want 1 0 200 deadbeef 1", bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait); tests_failed++;
        end
        tick();
        bus.ramstate = FREE; bus.daddr = 32'h999; bus.dstore = 32'h0;
        @(negedge CLK);
        tests_run++;
        if (bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1 || dut.state !== RECOVER) begin
            $display("FAIL store_recover: got wen=%0b dwait=%0b state=%0d want 0 1 RECOVER", bus.ramWEN, bus.dwait, dut.state); tests_failed++;
        end
        tick();
        bus.ramstate = ACCESS;
        @(negedge CLK);
        tests_run++;
        if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h200 || bus.ramstore !== 32'hDEADBEEF || bus.dwait !== 1'b0 || bus.dload !== 32'h0) begin
            $display("FAIL store_retry: got wen=%0b addr=%h store=%h dwait=%0b dload=%h want 1 200 deadbeef 0 0", bus.ramWEN, bus.ramaddr, bus.ramstore, bus.dwait, bus.dload); tests_failed++;
        end
        tick();
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        @(negedge CLK);
        tests_run++;
        if (bus.ramWEN !== 1'b0 || bus.dwait !== 1'b1) begin
            $display("FAIL store_after: got wen=%0b dwait=%0b want 0 1", bus.ramWEN, bus.dwait); tests_failed++;
        end
    endtask

    task automatic test_abandon();
        tick();
        bus.dREN = 1'b1; bus.daddr = 32'h400; bus.ramstate = FREE;
        tick();
        bus.ramstate = BUSY; bus.dREN = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h400 || bus.dwait !== 1'b1) begin
            $display("FAIL abandon_busy: got ren=%0b addr=%h dwait=%0b want 1 400 1", bus.ramREN, bus.ramaddr, bus.dwait); tests_failed++;
        end
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h55;
        @(negedge CLK);
        tests_run++;
        if (bus.ramREN !== 1'b1 || bus.dwait !== 1'b1 || bus.dload !== 32'h0) begin
            $display("FAIL abandon_access: got ren=%0b dwait=%0b dload=%h want 1 1 0", bus.ramREN, bus.dwait, bus.dload); tests_failed++;
        end
        tick();
        bus.ramstate = FREE;
        @(negedge CLK);
        tests_run++;
        if (dut.state !== IDLE || bus.ramREN !== 1'b0) begin
            $display("FAIL abandon_idle: got state=%0d ren=%0b want IDLE 0", dut.state, bus.ramREN); tests_failed++;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_store_error();
        test_abandon();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates a single-ported RAM between the instruction-fetch and data requesters of one CPU's cache block. Sits between the caches block and the RAM model.
- Registered FSM grants one transaction at a time.
- Latches address and store data at grant.
- Returns wait/load per requester, with data priority and bounded instruction starvation.

Parameters:
STARVE_MAX, 4, max consecutive data grants allowed while an instruction request is pending (1..15)
ADDR_W, 32, address width (word_t)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request
iaddr  in  32  instruction address
iwait  out  1  low = instruction data valid this cycle
iload  out  32  instruction read data
dREN  in  1  data read request
dWEN  in  1  data write request (dREN&dWEN both high is illegal; dWEN wins)
daddr  in  32  data address
dstore  in  32  data write value
dwait  out  1  low = data transaction completes this cycle
dload  out  32  data read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - state=IDLE; starve_cnt=0; addr_q=0; store_q=0.
  - ramREN=ramWEN=0; ramaddr=ramstore=0.
  - iwait=dwait=1; iload=dload=0.
- States: IDLE, IFETCH, DLOAD, DSTORE, RECOVER.
- IDLE arbitration (decided on the edge):
  - dWEN → DSTORE.
  - else dREN → DLOAD.
  - else iREN → IFETCH.
  - Exception: if iREN && starve_cnt==STARVE_MAX → IFETCH, even with a data request pending.
- Grant edge: addr_q←granted addr; store_q←dstore for DSTORE.
- starve_cnt update:
  - Increments on each data grant while iREN is high; saturates at STARVE_MAX.
  - Clears on an IFETCH grant, or when iREN is low in IDLE.
- RAM drive:
  - In IFETCH/DLOAD: ramREN=1.
  - In DSTORE: ramWEN=1.
  - ramaddr=addr_q; ramstore=store_q.
  - All strobes are 0 in IDLE/RECOVER.
- Completion: in the active state, when ramstate==ACCESS:
  - Owning wait goes low combinationally that same cycle.
  - iload/dload=ramload (read states); otherwise load=0.
  - Next state is IDLE.
- FREE/BUSY: hold the state; wait stays high.
- ERROR: wait stays high; next state RECOVER (1 cycle, strobes low), then back to the same transaction state with the same addr_q/store_q (retry).
- Requester waits are high in every cycle that is not its own completion cycle, including IDLE.
- Latency: request sampled at edge n; earliest completion is cycle n+1 (2-cycle minimum from assertion).
  - Back-to-back transactions pass through IDLE for 1 cycle.
- Requester deasserts mid-transaction: the RAM transaction still completes; the result is discarded; the wait is not lowered for it.
- Reset mid-transaction: strobes drop immediately (asynchronous); no retry.

Optional Feature:
MEM_ARB_STATS_EN:
- Defined: adds output ports igrants[15:0], dgrants[15:0], errcnt[15:0].
  - Each is a saturating count of IFETCH grants, data grants and ERROR responses.
  - All reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg holds:
  - word_t.
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR).
  - New arb_state_t enum (IDLE/IFETCH/DLOAD/DSTORE/RECOVER).
- One natural sub-module: arb_starve_ctr, a saturating counter with STARVE_MAX parameter, inc/clr inputs and an at_max output.

Test Plan:
1. Reset: nRST=0 asynchronously mid-cycle → ramREN=ramWEN=0, iwait=dwait=1 immediately; state IDLE after release.
2. Single fetch: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x2402000A → iwait low exactly 1 cycle, iload=0x2402000A, ramaddr=0x40 during the transaction.
3. Priority: iREN and dREN both high, daddr=0x100 → DLOAD granted first, dwait low first; IFETCH follows after 1 IDLE cycle.
4. Starvation, STARVE_MAX=4: iREN held high, dREN held high → exactly 4 data grants, then the 5th grant is IFETCH; starve_cnt=0 afterwards.
5. Store with error: dWEN=1, daddr=0x200, dstore=0xDEADBEEF; ramstate ERROR once, then ACCESS → RECOVER 1 cycle, retry with ramaddr=0x200 and ramstore=0xDEADBEEF; dwait low once.
6. Abandoned request: dREN dropped during BUSY → the RAM read completes, dwait stays high, and the FSM returns to IDLE.
